avmm_ccip_burst_splitter: RTL and testbench

Avalon-MM burst splitter sitting directly upstream of the AVMM-to-CCI-P host bridge. It accepts arbitrary-length, cache-line-granular Avalon-MM read and write bursts (1..64 lines) from DMA or AFU masters. It re-issues each burst as a sequence of CCI-P-legal sub-bursts: length 1, 2 or 4 lines, with the start line naturally aligned to the sub-burst length. Read data returns through the block unmodified.

---
 rtl/avmm_ccip_burst_splitter.sv | 199 +++++++++++++++++++
 tb/tb_avmm_ccip_burst_splitter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_ccip_burst_splitter.sv
// Splits cache-line-granular Avalon-MM bursts (1..64 lines) into CCI-P-legal
// sub-bursts of 1, 2 or 4 lines, each naturally aligned to its own length.
module avmm_ccip_burst_splitter #(
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_WIDTH = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     s_address,
    input  logic [BURST_WIDTH-1:0]    s_burstcount,
    input  logic                      s_read,
    input  logic                      s_write,
    input  logic [DATA_WIDTH-1:0]     s_writedata,
    input  logic [DATA_WIDTH/8-1:0]   s_byteenable,
    output logic                      s_waitrequest,
    output logic [DATA_WIDTH-1:0]     s_readdata,
    output logic                      s_readdatavalid,
    output logic [ADDR_WIDTH-1:0]     m_address,
    output logic [2:0]                m_burstcount,
    output logic                      m_read,
    output logic                      m_write,
    output logic [DATA_WIDTH-1:0]     m_writedata,
    output logic [DATA_WIDTH/8-1:0]   m_byteenable,
    input  logic                      m_waitrequest,
    input  logic [DATA_WIDTH-1:0]     m_readdata,
    input  logic                      m_readdatavalid
);

    localparam int LW = ADDR_WIDTH - 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_SPLIT = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          cl_q, cl_d;
    logic [LW-1:0]          base_q, base_d;
    logic [BURST_WIDTH-1:0] rem_q, rem_d;
    logic [2:0]             sub_left_q, sub_left_d;
    logic [2:0]             sub_len_q, sub_len_d;

    logic                   m_read_c, m_write_c, s_wait_c;
    logic [ADDR_WIDTH-1:0]  m_address_c;
    logic [2:0]             m_burstcount_c;

    // Largest aligned CCI-P sub-burst that fits at this line.
    function automatic logic [2:0] len_f(input logic [LW-1:0] line,
                                         input logic [BURST_WIDTH-1:0] rem);
        logic [2:0] len;
        if (line[1:0] == 2'b00 && rem >= BURST_WIDTH'(4)) begin
            len = 3'd4;
        end else if (!line[0] && rem >= BURST_WIDTH'(2)) begin
            len = 3'd2;
        end else begin
            len = 3'd1;
        end
        return len;
    endfunction

    logic [LW-1:0]          s_line, s_line_inc, cl_inc;
    logic [BURST_WIDTH-1:0] s_rem_dec, rem_dec;
    logic [2:0]             s_len, rd_len;
    logic                   unused_addr_lsbs;

    assign s_line     = s_address[ADDR_WIDTH-1:6];
    assign s_line_inc = s_line + LW'(1);
    assign s_rem_dec  = s_burstcount - BURST_WIDTH'(1);
    assign s_len      = len_f(s_line, s_burstcount);
    assign cl_inc     = cl_q + LW'(1);
    assign rem_dec    = rem_q - BURST_WIDTH'(1);
    assign rd_len     = len_f(cl_q, rem_q);
    assign unused_addr_lsbs = ^s_address[5:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cl_q       <= '0;
            base_q     <= '0;
            rem_q      <= '0;
            sub_left_q <= '0;
            sub_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            cl_q       <= cl_d;
            base_q     <= base_d;
            rem_q      <= rem_d;
            sub_left_q <= sub_left_d;
            sub_len_q  <= sub_len_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cl_d           = cl_q;
        base_d         = base_q;
        rem_d          = rem_q;
        sub_left_d     = sub_left_q;
        sub_len_d      = sub_len_q;
        m_read_c       = 1'b0;
        m_write_c      = 1'b0;
        m_address_c    = '0;
        m_burstcount_c = 3'd0;
        s_wait_c       = 1'b1;

        case (state_q)
            IDLE: begin
                if (s_read) begin
                    s_wait_c = 1'b0;
                    if (s_burstcount != '0) begin
                        cl_d    = s_line;
                        rem_d   = s_burstcount;
                        state_d = RD_SPLIT;
                    end
                end else if (s_write) begin
                    if (s_burstcount == '0) begin
                        s_wait_c = 1'b0;
                    end else begin
                        // First write beat goes straight through with no added latency.
                        m_write_c      = 1'b1;
                        m_address_c    = {s_line, 6'b0};
                        m_burstcount_c = s_len;
                        s_wait_c       = m_waitrequest;
                        if (!m_waitrequest && s_burstcount != BURST_WIDTH'(1)) begin
                            cl_d    = s_line_inc;
                            rem_d   = s_rem_dec;
                            state_d = WR_BURST;
                            if (s_len == 3'd1) begin
                                base_d     = s_line_inc;
                                sub_len_d  = len_f(s_line_inc, s_rem_dec);
                                sub_left_d = len_f(s_line_inc, s_rem_dec);
                            end else begin
                                base_d     = s_line;
                                sub_len_d  = s_len;
                                sub_left_d = s_len - 3'd1;
                            end
                        end
                    end
                end else begin
                    s_wait_c = m_waitrequest;
                end
            end

            RD_SPLIT: begin
                m_read_c       = 1'b1;
                m_address_c    = {cl_q, 6'b0};
                m_burstcount_c = rd_len;
                if (!m_waitrequest) begin
                    cl_d  = cl_q + LW'(rd_len);
                    rem_d = rem_q - BURST_WIDTH'(rd_len);
                    if (rem_q == BURST_WIDTH'(rd_len)) begin
                        state_d = IDLE;
                    end
                end
            end

            WR_BURST: begin
                // Base address stays fixed for the whole sub-burst; the host sequences line LSBs.
                m_write_c      = s_write;
                m_address_c    = {base_q, 6'b0};
                m_burstcount_c = sub_len_q;
                s_wait_c       = m_waitrequest;
                if (s_write && !m_waitrequest) begin
                    cl_d       = cl_inc;
                    rem_d      = rem_dec;
                    sub_left_d = sub_left_q - 3'd1;
                    if (rem_q == BURST_WIDTH'(1)) begin
                        state_d = IDLE;
                    end else if (sub_left_q == 3'd1) begin
                        base_d     = cl_inc;
                        sub_len_d  = len_f(cl_inc, rem_dec);
                        sub_left_d = len_f(cl_inc, rem_dec);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset must silence the master side immediately, even though IDLE decodes s_write combinationally.
    assign m_read          = m_read_c & ~reset;
    assign m_write         = m_write_c & ~reset;
    assign s_waitrequest   = s_wait_c | reset;
    assign m_address       = m_address_c;
    assign m_burstcount    = m_burstcount_c;
    assign m_writedata     = s_writedata;
    assign m_byteenable    = s_byteenable;
    assign s_readdata      = m_readdata;
    assign s_readdatavalid = m_readdatavalid;

    a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(state_q == IDLE && s_read && s_write));

endmodule

// File: tb/tb_avmm_ccip_burst_splitter.sv
// Randomized bench for avmm_ccip_burst_splitter: every master transfer is
// compared against a sub-burst list derived from the line-length rule.
module tb_avmm_ccip_burst_splitter;

    logic          clk = 1'b0;
    logic          reset;
    logic [47:0]   s_address;
    logic [6:0]    s_burstcount;
    logic          s_read, s_write;
    logic [511:0]  s_writedata;
    logic [63:0]   s_byteenable;
    logic          s_waitrequest;
    logic [511:0]  s_readdata;
    logic          s_readdatavalid;
    logic [47:0]   m_address;
    logic [2:0]    m_burstcount;
    logic          m_read, m_write;
    logic [511:0]  m_writedata;
    logic [63:0]   m_byteenable;
    logic          m_waitrequest;
    logic [511:0]  m_readdata;
    logic          m_readdatavalid;

    avmm_ccip_burst_splitter dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_burstcount(s_burstcount),
        .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .m_address(m_address), .m_burstcount(m_burstcount),
        .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [47:0] addr;
        logic [2:0]  bc;
        logic [63:0] data;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [63:0] wdata[64];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          stall_en = 1'b0;
    logic        force_wr = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: walk the burst line by line, picking the largest aligned sub-burst that fits.
    task automatic model_push(input bit wr, input logic [47:0] addr, input int bc);
        logic [41:0] line;
        int          rem, len, beat;
        xfer_t       e;
        line = addr[47:6];
        rem  = bc;
        beat = 0;
        while (rem > 0) begin
            if (line[1:0] == 2'b00 && rem >= 4)  len = 4;
            else if (line[0] == 1'b0 && rem >= 2) len = 2;
            else                                  len = 1;
            e.wr   = wr;
            e.addr = {line, 6'b0};
            e.bc   = 3'(len);
            e.data = 64'd0;
            if (!wr) begin
                exp_q.push_back(e);
            end else begin
                for (int j = 0; j < len; j++) begin
                    e.data = wdata[beat];
                    exp_q.push_back(e);
                    beat++;
                end
            end
            line = line + 42'(len);
            rem  = rem - len;
        end
    endtask

    // Master-side stall generator; sole driver of m_waitrequest.
    always @(posedge clk) begin
        #1;
        m_waitrequest <= stall_en ? ($urandom_range(0, 2) == 0) : force_wr;
    end

    logic        p_valid = 1'b0;
    logic [63:0] p_vec;
    always @(negedge clk) begin
        xfer_t e;
        if (!reset) begin
            if (p_valid)
                check("hold_stable", 64'({m_read, m_write, m_address, m_burstcount}), p_vec);
            if (m_read || m_write) begin
                check("rd_wr_excl", 64'(m_read && m_write), 64'd0);
                if (!m_waitrequest) begin
                    $display("xfer %s addr=0x%0h bc=%0d wd=0x%0h", m_write ? "wr" : "rd",
                             m_address, m_burstcount, m_writedata[63:0]);
                    if (exp_q.size() == 0) begin
                        check("spurious_xfer", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_kind", 64'(m_write), 64'(e.wr));
                        check("xfer_addr", 64'(m_address), 64'(e.addr));
                        check("xfer_bcnt", 64'(m_burstcount), 64'(e.bc));
                        if (e.wr) check("xfer_wdata", m_writedata[63:0], e.data);
                    end
                end
            end
        end
        p_valid <= !reset && (m_read || m_write) && m_waitrequest;
        p_vec   <= 64'({m_read, m_write, m_address, m_burstcount});
    end

    task automatic wait_accept(input string tag);
        int n = 0;
        @(negedge clk);
        while (s_waitrequest && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(s_waitrequest), 64'd0);
    endtask

    task automatic do_read(input logic [47:0] addr, input int bc);
        model_push(1'b0, addr, bc);
        s_read       = 1'b1;
        s_address    = addr;
        s_burstcount = 7'(bc);
        wait_accept("rd_accept");
        @(posedge clk); #1;
        s_read = 1'b0;
    endtask

    task automatic do_write(input logic [47:0] addr, input int bc, input bit gaps);
        for (int i = 0; i < bc; i++) wdata[i] = {$urandom, $urandom};
        model_push(1'b1, addr, bc);
        for (int i = 0; i < bc; i++) begin
            s_write      = 1'b1;
            s_address    = addr;
            s_burstcount = 7'(bc);
            s_writedata  = {448'd0, wdata[i]};
            s_byteenable = '1;
            wait_accept("wr_accept");
            @(posedge clk); #1;
            s_write = 1'b0;
            if (gaps) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] r;
        logic [47:0] a;
        int          bc;

        reset = 1'b1;
        s_address = '0; s_burstcount = 7'd1; s_read = 1'b0; s_write = 1'b1;
        s_writedata = '0; s_byteenable = '1;
        m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;

        // Reset gating while a write is being presented.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mread", 64'(m_read), 64'd0);
        check("rst_mwrite", 64'(m_write), 64'd0);
        check("rst_swait", 64'(s_waitrequest), 64'd1);
        s_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_swait", 64'(s_waitrequest), 64'd0);
        check("idle_mread", 64'(m_read), 64'd0);
        @(posedge clk); #1;

        // Read 0x40 x7: cycle-exact handshake timing.
        model_push(1'b0, 48'h40, 7);
        s_read = 1'b1; s_address = 48'h40; s_burstcount = 7'd7;
        @(negedge clk);
        check("rd7_c0_swait", 64'(s_waitrequest), 64'd0);
        @(posedge clk); #1;
        s_read = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("rd7_mread", 64'(m_read), 64'd1);
            check("rd7_swait", 64'(s_waitrequest), 64'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rd7_c4_swait", 64'(s_waitrequest), 64'd0);
        check("rd7_c4_mread", 64'(m_read), 64'd0);
        drain("rd7_drain");

        do_write(48'hC0, 2, 1'b0);
        drain("wr_c0_drain");
        do_write(48'h80, 6, 1'b1);
        drain("wr_80_drain");
        do_write(48'h1C0, 3, 1'b0);
        do_write(48'h200, 5, 1'b0);
        drain("wr_b2b_drain");

        stall_en = 1'b1;
        do_read(48'h0, 64);
        drain("rd64_drain");
        do_read(48'hFFFF_FFFF_FFC0, 2);
        drain("rd_wrap_drain");
        stall_en = 1'b0;
        @(posedge clk); #1;

        // Reset on the third beat of a 4-beat write.
        for (int i = 0; i < 4; i++) wdata[i] = {$urandom, $urandom};
        model_push(1'b1, 48'h0, 4);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        for (int i = 0; i < 3; i++) begin
            s_write = 1'b1; s_address = 48'h0; s_burstcount = 7'd4;
            s_writedata = {448'd0, wdata[i]};
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        #1 reset = 1'b1;
        @(negedge clk);
        check("mid_rst_mwrite", 64'(m_write), 64'd0);
        check("mid_rst_swait", 64'(s_waitrequest), 64'd1);
        s_write = 1'b0;
        force_wr = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_swait_hi", 64'(s_waitrequest), 64'd1);
        force_wr = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_swait_lo", 64'(s_waitrequest), 64'd0);
        check("post_rst_mwrite", 64'(m_write), 64'd0);
        check("mid_rst_queue", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // Zero-length commands are swallowed.
        s_write = 1'b1; s_burstcount = 7'd0; s_address = 48'h140;
        @(negedge clk);
        check("bc0_wr_mwrite", 64'(m_write), 64'd0);
        check("bc0_wr_swait", 64'(s_waitrequest), 64'd0);
        @(posedge clk); #1;
        s_write = 1'b0; s_read = 1'b1;
        @(negedge clk);
        check("bc0_rd_mread", 64'(m_read), 64'd0);
        @(posedge clk); #1;
        s_read = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bc0_quiet", 64'({m_read, m_write}), 64'd0);
        end
        @(posedge clk); #1;

        // Read data path is a pure pass-through.
        for (int i = 0; i < 4; i++) begin
            r = {$urandom, $urandom};
            m_readdata = {448'd0, r};
            m_readdatavalid = (i % 2) == 1;
            @(negedge clk);
            check("rdata_pass", s_readdata[63:0], r);
            check("rvalid_pass", 64'(s_readdatavalid), 64'((i % 2) == 1));
            @(posedge clk); #1;
        end
        m_readdatavalid = 1'b0;

        // Randomized mix with master stalls and write gaps.
        stall_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            a  = {$urandom, $urandom};
            bc = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 64);
            if (bc == 0 || $urandom_range(0, 1) == 0) do_read(a, bc);
            else do_write(a, bc, $urandom_range(0, 1) == 1);
            drain("rand_drain");
        end
        stall_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
